// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - segment patterns and segment indices for the seven-segment decoder
package seven_seg_pkg;

    // Logical (active-high) patterns, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0    = 7'h7E;
    localparam logic [6:0] SEG_1    = 7'h30;
    localparam logic [6:0] SEG_2    = 7'h6D;
    localparam logic [6:0] SEG_3    = 7'h79;
    localparam logic [6:0] SEG_4    = 7'h33;
    localparam logic [6:0] SEG_5    = 7'h5B;
    localparam logic [6:0] SEG_6    = 7'h5F;
    localparam logic [6:0] SEG_7    = 7'h70;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h7B;
    localparam logic [6:0] SEG_A    = 7'h77;
    localparam logic [6:0] SEG_B    = 7'h1F;
    localparam logic [6:0] SEG_C    = 7'h4E;
    localparam logic [6:0] SEG_D    = 7'h3D;
    localparam logic [6:0] SEG_E    = 7'h4F;
    localparam logic [6:0] SEG_F    = 7'h47;
    localparam logic [6:0] SEG_DASH = 7'h01;
    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [6:0] SEG_ALL  = 7'h7F;

    // Position of each segment inside the 7-bit drive word
    localparam int SEG_IDX_A = 6;
    localparam int SEG_IDX_B = 5;
    localparam int SEG_IDX_C = 4;
    localparam int SEG_IDX_D = 3;
    localparam int SEG_IDX_E = 2;
    localparam int SEG_IDX_F = 1;
    localparam int SEG_IDX_G = 0;

    // Highest code that is a valid decimal digit
    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/seven_seg_if.sv
// rtl/seven_seg_if.sv - digit request and segment drive bundle for one display digit
interface seven_seg_if;
    logic [3:0] bcd;
    logic       blank;
    logic       lamp_test;
    logic [6:0] seg;
    logic       bcd_err;

    // Digit-select logic drives the request and observes the drive lines
    modport master (
        output bcd,
        output blank,
        output lamp_test,
        input  seg,
        input  bcd_err
    );

    // Decoder consumes the request and produces the drive lines
    modport slave (
        input  bcd,
        input  blank,
        input  lamp_test,
        output seg,
        output bcd_err
    );
endinterface

// File: rtl/seven_seg_lut.sv
// rtl/seven_seg_lut.sv - combinational 4-bit code to logical segment pattern
module seven_seg_lut
    import seven_seg_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Codes 10-15 show either hex glyphs or a dash depending on HEX_MODE
    always_comb begin
        seg = SEG_DASH;
        case (code)
            4'd0:  seg = SEG_0;
            4'd1:  seg = SEG_1;
            4'd2:  seg = SEG_2;
            4'd3:  seg = SEG_3;
            4'd4:  seg = SEG_4;
            4'd5:  seg = SEG_5;
            4'd6:  seg = SEG_6;
            4'd7:  seg = SEG_7;
            4'd8:  seg = SEG_8;
            4'd9:  seg = SEG_9;
            4'd10: seg = (HEX_MODE != 0) ? SEG_A : SEG_DASH;
            4'd11: seg = (HEX_MODE != 0) ? SEG_B : SEG_DASH;
            4'd12: seg = (HEX_MODE != 0) ? SEG_C : SEG_DASH;
            4'd13: seg = (HEX_MODE != 0) ? SEG_D : SEG_DASH;
            4'd14: seg = (HEX_MODE != 0) ? SEG_E : SEG_DASH;
            4'd15: seg = (HEX_MODE != 0) ? SEG_F : SEG_DASH;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg.sv
// rtl/seven_seg.sv - registered BCD to seven-segment decoder with blank and lamp test
module seven_seg
    import seven_seg_pkg::*;
#(
    parameter int ACTIVE_LOW = 0,
    parameter int HEX_MODE   = 0
) (
    input  logic        clk,
    input  logic        rst,
    seven_seg_if.slave  io
);

    // Physical level of a fully dark digit for the chosen polarity
    localparam logic [6:0] SEG_RESET = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;

    logic [6:0] lut_seg;
    logic [6:0] sel_seg;
    logic [6:0] drive_seg;
    logic [6:0] seg_q;
    logic       err_q;

    seven_seg_lut #(
        .HEX_MODE (HEX_MODE)
    ) u_lut (
        .code (io.bcd),
        .seg  (lut_seg)
    );

    // Override mux: lamp test beats blank, blank beats the decoded digit
    always_comb begin
        sel_seg = lut_seg;
        if (io.lamp_test) begin
            sel_seg = SEG_ALL;
        end else if (io.blank) begin
            sel_seg = SEG_OFF;
        end
    end

    // Polarity is applied before the register so the pins never glitch
    assign drive_seg = (ACTIVE_LOW != 0) ? ~sel_seg : sel_seg;

    // Output registers; reset darkens the digit without waiting for a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_RESET;
            err_q <= 1'b0;
        end else begin
            seg_q <= drive_seg;
            err_q <= (io.bcd > BCD_MAX);
        end
    end

    assign io.seg     = seg_q;
    assign io.bcd_err = err_q;

endmodule

// File: tb/tb_seven_seg.sv
// tb/tb_seven_seg.sv - scoreboard bench for seven_seg across polarity and hex-mode variants
module tb_seven_seg;

    typedef struct {
        int         id;
        logic [6:0] seg;
        logic       err;
        string      tag;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] bcd;
    logic       blank;
    logic       lamp_test;

    exp_t q[$];
    event chk_ev;
    int   passed;
    int   total;

    logic [6:0] act_seg [3];
    logic       act_err [3];

    seven_seg_if if0 ();
    seven_seg_if if1 ();
    seven_seg_if if2 ();

    assign if0.bcd = bcd;  assign if0.blank = blank;  assign if0.lamp_test = lamp_test;
    assign if1.bcd = bcd;  assign if1.blank = blank;  assign if1.lamp_test = lamp_test;
    assign if2.bcd = bcd;  assign if2.blank = blank;  assign if2.lamp_test = lamp_test;

    assign act_seg[0] = if0.seg;  assign act_err[0] = if0.bcd_err;
    assign act_seg[1] = if1.seg;  assign act_err[1] = if1.bcd_err;
    assign act_seg[2] = if2.seg;  assign act_err[2] = if2.bcd_err;

    // dut0: active-high, dash mode; dut1: active-high, hex mode; dut2: active-low, dash mode
    seven_seg #(.ACTIVE_LOW(0), .HEX_MODE(0)) dut0 (.clk(clk), .rst(rst), .io(if0));
    seven_seg #(.ACTIVE_LOW(0), .HEX_MODE(1)) dut1 (.clk(clk), .rst(rst), .io(if1));
    seven_seg #(.ACTIVE_LOW(1), .HEX_MODE(0)) dut2 (.clk(clk), .rst(rst), .io(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] digit_pat(input logic [3:0] b, input bit hex);
        case (b)
            4'd0:  return 7'h7E;
            4'd1:  return 7'h30;
            4'd2:  return 7'h6D;
            4'd3:  return 7'h79;
            4'd4:  return 7'h33;
            4'd5:  return 7'h5B;
            4'd6:  return 7'h5F;
            4'd7:  return 7'h70;
            4'd8:  return 7'h7F;
            4'd9:  return 7'h7B;
            4'd10: return hex ? 7'h77 : 7'h01;
            4'd11: return hex ? 7'h1F : 7'h01;
            4'd12: return hex ? 7'h4E : 7'h01;
            4'd13: return hex ? 7'h3D : 7'h01;
            4'd14: return hex ? 7'h4F : 7'h01;
            default: return hex ? 7'h47 : 7'h01;
        endcase
    endfunction

    function automatic logic [6:0] logic_pat(input logic [3:0] b, input logic bl,
                                             input logic lt, input bit hex);
        if (lt) return 7'h7F;
        if (bl) return 7'h00;
        return digit_pat(b, hex);
    endfunction

    task automatic push_all(input logic [6:0] p0, input logic [6:0] p1,
                            input logic [6:0] p2, input logic e, input string tag);
        exp_t x;
        x.err = e; x.tag = tag;
        x.id = 0; x.seg = p0; q.push_back(x);
        x.id = 1; x.seg = p1; q.push_back(x);
        x.id = 2; x.seg = p2; q.push_back(x);
    endtask

    // Drive one request at the falling edge; the result is due after the next rising edge
    task automatic step(input logic [3:0] b, input logic bl, input logic lt, input string tag);
        logic [6:0] l0;
        logic [6:0] l1;
        @(negedge clk);
        bcd = b; blank = bl; lamp_test = lt; rst = 1'b0;
        l0 = logic_pat(b, bl, lt, 1'b0);
        l1 = logic_pat(b, bl, lt, 1'b1);
        push_all(l0, l1, ~l0, (b >= 4'd10), tag);
    endtask

    // Assert reset away from any clock edge and check the outputs clear at once
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        push_all(7'h00, 7'h00, 7'h7F, 1'b0, tag);
        ->chk_ev;
    endtask

    // Monitor: after each rising edge or immediate-check request, compare all due entries
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (act_seg[e.id] === e.seg) passed++;
                else $display("FAIL %s dut%0d seg: got %h expected %h", e.tag, e.id, act_seg[e.id], e.seg);
                total++;
                if (act_err[e.id] === e.err) passed++;
                else $display("FAIL %s dut%0d bcd_err: got %b expected %b", e.tag, e.id, act_err[e.id], e.err);
            end
        end
    end

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1; bcd = 4'd0; blank = 1'b0; lamp_test = 1'b0;
        #2;
        push_all(7'h00, 7'h00, 7'h7F, 1'b0, "reset");
        ->chk_ev;

        for (int i = 0; i < 16; i++) step(i[3:0], 1'b0, 1'b0, "sweep");

        step(4'd5,  1'b1, 1'b0, "blank");
        step(4'd5,  1'b1, 1'b1, "lamp_over_blank");
        step(4'd5,  1'b0, 1'b0, "release");
        step(4'd12, 1'b1, 1'b0, "err_while_blank");
        step(4'd14, 1'b0, 1'b1, "err_while_lamp");

        step(4'd3,  1'b0, 1'b0, "pre_reset");
        async_reset("mid_reset");
        repeat (2) @(posedge clk);
        step(4'd3,  1'b0, 1'b0, "post_reset");
        step(4'd8,  1'b0, 1'b0, "eight");

        repeat (3) @(posedge clk);
        #4;
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expected entries never checked, expected 0", q.size());
            total += q.size();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
